// File: rtl/nibble_addsub_seq_pkg.sv
// addsub_pkg: shared constants, FSM state type and nibble-count helper for the nibble add/sub sequencer.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_addsub_seq_slice.sv
// addsub4_slice: combinational 4-bit add slice; the caller pre-inverts b for subtraction.
module addsub4_slice
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_addsub_seq.sv
// nibble_addsub_seq: WIDTH-bit add/sub done one nibble per cycle, LSB first, through a shared 4-bit slice.
// Optional res_zero output when ADDSUB_SEQ_ZERO_FLAG_EN is defined.
module nibble_addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             res_cout,
    output logic             res_ovf
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    ,
    output logic             res_zero
`endif
);

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int IDX_W   = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               m_q, m_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               valid_q, valid_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    logic               zero_q, zero_d;
`endif

    logic [NIBBLE_W-1:0] sl_a, sl_b, sl_sum;
    logic                sl_cout;
    logic                last;

    assign sl_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign sl_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{m_q}};
    assign last = idx_q == IDX_W'(NIBBLES - 1);

    addsub4_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        res_d   = res_q;
        valid_d = valid_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        unique case (state_q)
            IDLE: if (start_valid) begin
                a_d     = a;
                b_d     = b;
                m_d     = m;
                carry_d = m;
                idx_d   = '0;
                res_d   = '0;
                state_d = RUN;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
                zero_d  = 1'b1;
`endif
            end
            RUN: begin
                res_d[idx_q*NIBBLE_W +: NIBBLE_W] = sl_sum;
                carry_d = sl_cout;
                idx_d   = last ? '0 : idx_q + 1'b1;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
                zero_d  = zero_q & (sl_sum == '0);
`endif
                if (last) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    cout_d  = sl_cout;
                    // sl_sum MSB is the result MSB on the final nibble
                    ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ m_q)) &&
                              (sl_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                end
            end
            DONE: if (res_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign start_ready = state_q == IDLE;
    assign res_valid   = valid_q;
    assign res         = res_q;
    assign res_cout    = cout_q;
    assign res_ovf     = ovf_q;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    assign res_zero    = zero_q;
`endif

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// tb_nibble_addsub_seq: directed vector table, handshake corner cases and randomized ops against an arithmetic model.
module tb_nibble_addsub_seq;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         m = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res;
    logic         res_cout, res_ovf;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    logic         res_zero;
`endif

    nibble_addsub_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .m           (m),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .res_cout    (res_cout),
        .res_ovf     (res_ovf)
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        ,
        .res_zero    (res_zero)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a, b;
        logic         m;
        logic [W-1:0] r;
        logic         c, v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference computed from integer arithmetic, independent of nibble sequencing
    task automatic model(input logic [W-1:0] x, y, input logic mm,
                         output logic [W-1:0] r, output logic c, v);
        longint sx, sy, s, ux, uy;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - 65536 : ux;
        sy = y[W-1] ? uy - 65536 : uy;
        s  = mm ? sx - sy : sx + sy;
        v  = (s > 32767) || (s < -32768);
        c  = mm ? (ux >= uy) : (ux + uy > 65535);
        r  = mm ? x - y : x + y;
    endtask

    task automatic zero_now(output logic z);
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        z = res_zero;
`else
        z = 1'b0;
`endif
    endtask

    task automatic op(input logic [W-1:0] x, y, input logic mm, input int bp, input string tag,
                      output logic [W-1:0] r, output logic c, v, z);
        int cyc;
        @(negedge clk);
        cyc = 0;
        while (!start_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " start_ready"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a = x;
        b = y;
        m = mm;
        @(negedge clk);
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        m = 1'($urandom);
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(N));
        r = res;
        c = res_cout;
        v = res_ovf;
        zero_now(z);
        for (int i = 0; i < bp; i++) begin
            start_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            chk({tag, " bp valid"}, 32'(res_valid), 32'd1);
            chk({tag, " bp start_ready"}, 32'(start_ready), 32'd0);
            chk({tag, " bp res"}, 32'({res, res_cout, res_ovf}), 32'({r, c, v}));
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, " post valid"}, 32'(res_valid), 32'd0);
        chk({tag, " post start_ready"}, 32'(start_ready), 32'd1);
        chk({tag, " post res held"}, 32'(res), 32'(r));
    endtask

    task automatic check_reset_outputs(input string tag);
        logic z;
        zero_now(z);
        chk({tag, " valid"}, 32'(res_valid), 32'd0);
        chk({tag, " res"}, 32'(res), 32'd0);
        chk({tag, " cout/ovf/zero"}, 32'({res_cout, res_ovf, z}), 32'd0);
        chk({tag, " start_ready"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        vec_t         vt[7];
        logic [W-1:0] r, er, x, y;
        logic         c, v, z, ec, ev, mm;

        vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vt[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[6] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0001, 1'b1, 1'b0};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            op(vt[i].a, vt[i].b, vt[i].m, 0, $sformatf("vec%0d", i), r, c, v, z);
            chk($sformatf("vec%0d res", i), 32'(r), 32'(vt[i].r));
            chk($sformatf("vec%0d cout", i), 32'(c), 32'(vt[i].c));
            chk($sformatf("vec%0d ovf", i), 32'(v), 32'(vt[i].v));
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            chk($sformatf("vec%0d zero", i), 32'(z), 32'(vt[i].r == '0));
`endif
        end

        op(16'h1234, 16'h0FFF, 1'b0, 5, "backpressure", r, c, v, z);
        chk("backpressure res", 32'({r, c, v}), 32'({16'h2233, 1'b0, 1'b0}));

        @(negedge clk);
        start_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'h5555;
        m = 1'b0;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrun reset");
        repeat (3) @(negedge clk);
        chk("midrun reset no valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        op(16'hFFFF, 16'h0001, 1'b0, 0, "after reset", r, c, v, z);
        chk("after reset res", 32'({r, c}), 32'({16'h0000, 1'b1}));

        for (int i = 0; i < 40; i++) begin
            x  = W'($urandom);
            y  = (i % 8 == 0) ? x : W'($urandom);
            mm = 1'($urandom);
            op(x, y, mm, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i), r, c, v, z);
            model(x, y, mm, er, ec, ev);
            chk($sformatf("rnd%0d res", i), 32'(r), 32'(er));
            chk($sformatf("rnd%0d cout", i), 32'(c), 32'(ec));
            chk($sformatf("rnd%0d ovf", i), 32'(v), 32'(ev));
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            chk($sformatf("rnd%0d zero", i), 32'(z), 32'(er == '0));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
